// File: rtl/alu_mdu_seq_pkg.sv
// Shared encodings for the sequential RV32/64 execute unit: funct3 codes,
// op-field bit positions, FSM states and divide corner-case constants.
package alu_mdu_seq_pkg;

  localparam int OP_ALT = 8;
  localparam int OP_M   = 3;

  localparam logic [2:0] F3_ADD    = 3'd0;
  localparam logic [2:0] F3_SLL    = 3'd1;
  localparam logic [2:0] F3_SLT    = 3'd2;
  localparam logic [2:0] F3_SLTU   = 3'd3;
  localparam logic [2:0] F3_XOR    = 3'd4;
  localparam logic [2:0] F3_SR     = 3'd5;
  localparam logic [2:0] F3_OR     = 3'd6;
  localparam logic [2:0] F3_AND    = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Left-aligned so either XLEN takes its constant as the top XLEN bits.
  localparam logic [63:0] INT_MIN_64  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] DIV0_QUO_64 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALU   = 3'd1,
    ST_SHORT = 3'd2,
    ST_MUL   = 3'd3,
    ST_DIV   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/alu_mdu_seq_div_iter.sv
// Restoring radix-2 divider: XLEN iteration cycles on magnitudes, then one
// cycle where done_o is high and the sign-corrected q_o/r_o are presented.
module alu_mdu_seq_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            signed_i,
  output logic            done_o,
  output logic [XLEN-1:0] q_o,
  output logic [XLEN-1:0] r_o
);
  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            neg_quo_q, neg_rem_q, busy_q, fix_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   rem_sh, diff;

  always_comb begin
    a_mag  = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
    b_mag  = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      fix_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (kill_i) begin
      busy_q <= 1'b0;
      fix_q  <= 1'b0;
    end else begin
      fix_q <= 1'b0;
      if (start_i) begin
        rem_q     <= '0;
        quo_q     <= a_mag;
        dvs_q     <= b_mag;
        neg_quo_q <= signed_i && (a_i[XLEN-1] ^ b_i[XLEN-1]);
        neg_rem_q <= signed_i && a_i[XLEN-1];
        cnt_q     <= CW'(XLEN);
        busy_q    <= 1'b1;
      end else if (busy_q) begin
        // diff[XLEN] is the borrow: set means the trial subtraction failed.
        if (!diff[XLEN]) begin
          rem_q <= diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= rem_sh[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          fix_q  <= 1'b1;
        end
      end
    end
  end

  assign done_o = fix_q;
  assign q_o    = neg_quo_q ? -quo_q : quo_q;
  assign r_o    = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/alu_mdu_seq.sv
// Sequential RV32/64 execute unit: base ALU plus M extension behind
// valid/ready, with a counted multiply path and an iterative divider.
module alu_mdu_seq
  import alu_mdu_seq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_LAT  = 2,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [9:0]      op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output state_e          dbg_state_o
);
  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; out_valid/result/illegal then hold until out_ready is seen.
  localparam int              SHW      = $clog2(XLEN);
  localparam int              MCW      = $clog2(MUL_LAT + 1);
  localparam logic [XLEN-1:0] INT_MIN  = INT_MIN_64[63 -: XLEN];
  localparam logic [XLEN-1:0] DIV0_QUO = DIV0_QUO_64[63 -: XLEN];

  state_e            state_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic [2:0]        f3_q;
  logic              alt_q, ill_q, illegal_q, out_valid_q;
  logic [MCW-1:0]    mcnt_q;

  logic              in_m, in_signed, in_short, accept, div_start, div_done;
  state_e            in_state;
  logic [XLEN-1:0]   alu_d, mul_d, div_q, div_r;
  logic [SHW-1:0]    shamt;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic              unused_op;

  assign unused_op = ^{op[9], op[7:4]};

  always_comb begin
    in_m      = op[OP_M] && ENABLE_M;
    in_signed = !op[0];
    in_short  = (b == '0) || (in_signed && (a == INT_MIN) && (b == '1));
    if (!in_m)         in_state = ST_ALU;
    else if (!op[2])   in_state = ST_MUL;
    else if (in_short) in_state = ST_SHORT;
    else               in_state = ST_DIV;
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign div_start = accept && (in_state == ST_DIV);

  always_comb begin
    shamt = b_q[SHW-1:0];
    alu_d = '0;
    if (state_q == ST_SHORT) begin
      if (b_q == '0) alu_d = f3_q[1] ? a_q : DIV0_QUO;
      else           alu_d = f3_q[1] ? '0  : a_q;
    end else if (!ill_q) begin
      case (f3_q)
        F3_ADD:  alu_d = alt_q ? a_q - b_q : a_q + b_q;
        F3_SLL:  alu_d = a_q << shamt;
        F3_SLT:  alu_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
        F3_SLTU: alu_d = {{(XLEN-1){1'b0}}, a_q < b_q};
        F3_XOR:  alu_d = a_q ^ b_q;
        F3_SR: begin
          if (alt_q) alu_d = $signed(a_q) >>> shamt;
          else       alu_d = a_q >> shamt;
        end
        F3_OR:   alu_d = a_q | b_q;
        default: alu_d = a_q & b_q;
      endcase
    end
  end

  // The multiplier is one wide product; the extra MUL_LAT-1 cycles are slack
  // for retiming this path across the counted stages.
  always_comb begin
    a_ext = {{XLEN{a_q[XLEN-1] && ((f3_q == F3_MULH) || (f3_q == F3_MULHSU))}}, a_q};
    b_ext = {{XLEN{b_q[XLEN-1] && (f3_q == F3_MULH)}}, b_q};
    prod  = a_ext * b_ext;
    mul_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  alu_mdu_seq_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .kill_i   (flush),
    .start_i  (div_start),
    .a_i      (a),
    .b_i      (b),
    .signed_i (in_signed),
    .done_o   (div_done),
    .q_o      (div_q),
    .r_o      (div_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      f3_q        <= '0;
      alt_q       <= 1'b0;
      ill_q       <= 1'b0;
      mcnt_q      <= '0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ALU, ST_SHORT: begin
          result_q    <= alu_d;
          illegal_q   <= ill_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_MUL: begin
          if (mcnt_q == '0) begin
            result_q    <= mul_d;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            mcnt_q <= mcnt_q - MCW'(1);
          end
        end
        ST_DIV: begin
          if (div_done) begin
            result_q    <= f3_q[1] ? div_r : div_q;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Accepting from DONE overrides the return to IDLE: no bubble.
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        f3_q    <= op[2:0];
        alt_q   <= op[OP_ALT];
        ill_q   <= op[OP_M] && !ENABLE_M;
        mcnt_q  <= MCW'(MUL_LAT - 1);
        state_q <= in_state;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule
